u_type_exec_ctrl: RTL
=====================

# u_type_exec_ctrl

Multi-cycle sequencer for U-type instructions (LUI, AUIPC) in the RISC-V core. It accepts one instruction plus its PC over a valid/ready handshake and decodes the opcode. For AUIPC it arbitrates for the shared ALU with a request/grant pair and issues `ALU_ADD`. It then presents the result to the register-file writeback port over a second valid/ready handshake.

## Interface

Parameters:
- none (opcode constants fixed: LUI = 7'b0110111, AUIPC = 7'b0010111; ALU opcode from `alu_opcode.v`)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept instruction
- in_instr  in  32  raw instruction word
- in_pc  in  32  PC of that instruction
- alu_req  out  1  request for shared ALU
- alu_gnt  in  1  ALU granted this cycle; alu_result valid same cycle
- alu_op  out  3  ALU operation, constant `ALU_ADD
- alu_a  out  32  ALU operand A (latched PC)
- alu_b  out  32  ALU operand B (U immediate)
- alu_result  in  32  combinational ALU result
- wb_valid  out  1  writeback offered
- wb_ready  in  1  register file accepts writeback
- wb_rd  out  5  destination register
- wb_data  out  32  writeback value
- illegal  out  1  one-cycle pulse: accepted opcode not LUI/AUIPC
- busy  out  1  high in every state except IDLE
- retire_count  out  16  retired U-type instructions (see Configuration)

## Operation

- States: IDLE, DECODE, ALU, WB.
- Reset values: state IDLE, in_ready 1, alu_req 0, alu_op `ALU_ADD, alu_a/alu_b 0, wb_valid 0, wb_rd 0, wb_data 0, illegal 0, busy 0, retire_count 0. All internal latches cleared.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch instr and pc, go to DECODE.
- DECODE (always 1 cycle): rd = instr[11:7], imm = {instr[31:12], 12'b0}.
  - Opcode not LUI/AUIPC: illegal = 1 for this cycle, go to IDLE, no retire.
  - rd == 0 (LUI or AUIPC): architectural no-op. Retire, go to IDLE, no ALU request, no writeback.
  - LUI: result = imm, go to WB.
  - AUIPC: go to ALU.
- ALU:
  - alu_req = 1, alu_a = pc, alu_b = imm.
  - Hold all three until alu_gnt is sampled high.
  - On grant: capture alu_result (32-bit add, carry discarded, wraps mod 2^32), go to WB.
  - alu_a/alu_b are 0 outside ALU.
- WB:
  - wb_valid = 1; wb_rd and wb_data stable until handshake.
  - On wb_valid && wb_ready: retire, go to IDLE.
  - wb_valid never drops without a handshake.
- in_ready is 0 outside IDLE. New instructions cannot overlap; any instruction offered while busy simply waits.

## Timing

- Accept edge = cycle 0.
- LUI:
  - DECODE in cycle 1, wb_valid first high in cycle 2.
  - With wb_ready tied high: IDLE in cycle 3; next accept at earliest cycle 3.
- AUIPC:
  - alu_req first high in cycle 2.
  - With gnt in cycle 2: wb_valid in cycle 3.
  - Each cycle of grant delay adds one cycle.
- illegal pulses in cycle 1; in_ready high again in cycle 2.
- rd == 0: in_ready high again in cycle 2, no wb_valid.
- Retire occurs on the edge leaving DECODE (rd == 0) or on the WB handshake edge.
- rst asserted mid-operation:
  - Immediately (asynchronously) forces all outputs to reset values.
  - The in-flight instruction is dropped with no writeback.

## Configuration

- Macro `U_EXEC_RETIRE_CNT_EN`.
- Defined:
  - retire_count is a 16-bit counter, +1 per retire, wraps 16'hFFFF -> 16'h0000.
  - Cleared only by rst.
- Undefined: retire_count tied to 16'h0000; no counter flops synthesized.
- All other behaviour identical in both builds.

## Test plan

- LUI: instr 32'h12345_0B7 (LUI x1), wb_ready = 1 -> wb_valid in cycle 2 with wb_rd = 1, wb_data = 32'h12345000; alu_req never high; retire_count = 1.
- AUIPC with delayed grant: instr 32'h00001_117 (AUIPC x2), pc = 32'h0000_1000, alu_gnt low 3 cycles then high -> alu_a/alu_b/alu_op held at 32'h1000 / 32'h1000 / `ALU_ADD; wb_data = 32'h0000_2000, wb_rd = 2.
- Backpressure and wrap: AUIPC with imm 32'hFFFFF000, pc = 32'h0000_2000 -> wb_data = 32'h0000_1000. With wb_ready low 4 cycles, wb_valid, wb_rd and wb_data stay stable and in_ready stays 0.
- Illegal and rd = 0: instr 32'h00000033 -> illegal pulses once, no wb_valid, count unchanged. LUI x0 (32'hABCDE037) -> no wb_valid, retire_count +1, in_ready high in cycle 2.
- Reset mid-op: assert rst while in ALU with alu_req high -> alu_req, busy and wb_valid are 0 asynchronously; after release, in_ready = 1 and retire_count = 0.
- Counter (macro defined): 65536 LUI retires -> retire_count returns to 0. With the macro undefined, it stays 0 throughout.

Source files
------------

// File: rtl/u_type_exec_ctrl_if.sv
// ---------------------------------------------------------------------------
// u_type_exec_ctrl_if
// Bundles every non-clock/reset signal of u_type_exec_ctrl.
//   Instruction intake : in_valid, in_ready, in_instr[31:0], in_pc[31:0]
//   Shared ALU port    : alu_req, alu_gnt, alu_op[2:0], alu_a[31:0],
//                        alu_b[31:0], alu_result[31:0]
//   Writeback port     : wb_valid, wb_ready, wb_rd[4:0], wb_data[31:0]
//   Status             : illegal, busy, retire_count[15:0]
// Modports:
//   slave  - the sequencer itself (accepts instructions, drives ALU/WB requests)
//   master - the surrounding core (offers instructions, grants ALU, sinks WB)
// ---------------------------------------------------------------------------
interface u_type_exec_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        alu_req;
  logic        alu_gnt;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic        busy;
  logic [15:0] retire_count;

  modport slave (
    input  in_valid, in_instr, in_pc, alu_gnt, alu_result, wb_ready,
    output in_ready, alu_req, alu_op, alu_a, alu_b, wb_valid, wb_rd, wb_data,
           illegal, busy, retire_count
  );

  modport master (
    output in_valid, in_instr, in_pc, alu_gnt, alu_result, wb_ready,
    input  in_ready, alu_req, alu_op, alu_a, alu_b, wb_valid, wb_rd, wb_data,
           illegal, busy, retire_count
  );
endinterface

// File: rtl/u_type_exec_ctrl.sv
// ---------------------------------------------------------------------------
// u_type_exec_ctrl
// Multi-cycle sequencer for RISC-V U-type instructions (LUI, AUIPC).
// Accepts one instruction + PC, decodes it, borrows the shared ALU for the
// AUIPC add, and hands the result to the register-file writeback port.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   io_bus - u_type_exec_ctrl_if.slave (intake, ALU, writeback, status)
//
// Build option:
//   U_EXEC_RETIRE_CNT_EN - when defined, retire_count is a wrapping 16-bit
//                          retire counter; otherwise it is tied to zero.
//
// All outputs are registers, loaded from the next-state value so that each
// one is already correct in the first cycle of the state it belongs to.
// ---------------------------------------------------------------------------
`ifndef ALU_ADD
`define ALU_ADD 3'b000
`endif

module u_type_exec_ctrl (
  input logic               clk,
  input logic               rst,
  u_type_exec_ctrl_if.slave io_bus
);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_ALU    = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_instr;
  logic [31:0] r_pc;

  logic        r_in_ready;
  logic        r_busy;
  logic        r_alu_req;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_illegal;

  logic        w_accept;
  logic        w_retire;
  logic [6:0]  w_opc;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;

  // True for the two opcodes this block executes.
  function automatic logic is_u_type(input logic [6:0] opc);
    return (opc == OPC_LUI) || (opc == OPC_AUIPC);
  endfunction

  assign w_opc    = r_instr[6:0];
  assign w_rd     = r_instr[11:7];
  assign w_imm    = {r_instr[31:12], 12'h000};
  assign w_accept = (r_state == S_IDLE) && io_bus.in_valid && r_in_ready;

  // Next-state decode and retire strobe.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_DECODE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_DECODE: begin
        if (!is_u_type(w_opc)) begin
          w_next = S_IDLE;
        end else if (w_rd == 5'd0) begin
          // Writes to x0 are architectural no-ops: retire without ALU or WB.
          w_next   = S_IDLE;
          w_retire = 1'b1;
        end else if (w_opc == OPC_LUI) begin
          w_next = S_WB;
        end else begin
          w_next = S_ALU;
        end
      end
      S_ALU: begin
        if (io_bus.alu_gnt) begin
          w_next = S_WB;
        end else begin
          w_next = S_ALU;
        end
      end
      S_WB: begin
        if (r_wb_valid && io_bus.wb_ready) begin
          w_next   = S_IDLE;
          w_retire = 1'b1;
        end else begin
          w_next = S_WB;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Instruction and PC capture on the intake handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= 32'h0000_0000;
      r_pc    <= 32'h0000_0000;
    end else if (w_accept) begin
      r_instr <= io_bus.in_instr;
      r_pc    <= io_bus.in_pc;
    end
  end

  // Handshake/status outputs, derived from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_alu_req  <= 1'b0;
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_in_ready <= (w_next == S_IDLE);
      r_busy     <= (w_next != S_IDLE);
      r_alu_req  <= (w_next == S_ALU);
      r_wb_valid <= (w_next == S_WB);
      // Decoded from the raw word at accept so the pulse lands on the DECODE cycle.
      r_illegal  <= w_accept && !is_u_type(io_bus.in_instr[6:0]);
    end
  end

  // ALU operands: driven only while in ALU, zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a <= 32'h0000_0000;
      r_alu_b <= 32'h0000_0000;
    end else if (w_next == S_ALU) begin
      r_alu_a <= r_pc;
      r_alu_b <= w_imm;
    end else begin
      r_alu_a <= 32'h0000_0000;
      r_alu_b <= 32'h0000_0000;
    end
  end

  // Writeback payload: loaded on entry to WB, then held through backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_rd   <= 5'd0;
      r_wb_data <= 32'h0000_0000;
    end else if ((r_state == S_DECODE) && (w_next == S_WB)) begin
      r_wb_rd   <= w_rd;
      r_wb_data <= w_imm;
    end else if ((r_state == S_ALU) && io_bus.alu_gnt) begin
      r_wb_rd   <= w_rd;
      r_wb_data <= io_bus.alu_result;
    end
  end

`ifdef U_EXEC_RETIRE_CNT_EN
  logic [15:0] r_retire_count;

  // Wrapping retire counter; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_count <= 16'h0000;
    end else if (w_retire) begin
      r_retire_count <= r_retire_count + 16'h0001;
    end
  end

  assign io_bus.retire_count = r_retire_count;
`else
  logic w_retire_unused;
  assign w_retire_unused     = w_retire;
  assign io_bus.retire_count = 16'h0000;
`endif

  assign io_bus.in_ready = r_in_ready;
  assign io_bus.busy     = r_busy;
  assign io_bus.alu_req  = r_alu_req;
  assign io_bus.alu_op   = `ALU_ADD;
  assign io_bus.alu_a    = r_alu_a;
  assign io_bus.alu_b    = r_alu_b;
  assign io_bus.wb_valid = r_wb_valid;
  assign io_bus.wb_rd    = r_wb_rd;
  assign io_bus.wb_data  = r_wb_data;
  assign io_bus.illegal  = r_illegal;

endmodule
